uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data byte width.
REQ-002 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of two).
REQ-003 SHALL have parameter CW, default 3, count width (log2(DEPTH)+1).
REQ-004 SHALL have one clock and an asynchronous active-low reset:
- clk  input  1  rising-edge clock
- arst_n  input  1  asynchronous, active-low reset
REQ-005 SHALL have the following control inputs:
- clear  input  1  synchronous soft clear
- enable  input  1  receive enable from register bank
REQ-006 SHALL connect to the receiver through these ports:
- rx_done  input  1  receiver frame-complete flag (level, held until receiver reset)
- rx_busy  input  1  receiver mid-frame
- rx_byte  input  WIDTH  receiver output byte
- rx_en  output  1  receiver enable
- rx_rst  output  1  receiver synchronous reset
REQ-007 SHALL have the following read-side and status ports:
- rd_req  input  1  pop FIFO head
- ovr_clr  input  1  clear overrun flag
- irq_level  input  CW  interrupt threshold
- rd_data  output  WIDTH  FIFO head (first-word-fall-through)
- count  output  CW  FIFO occupancy
- empty  output  1  count==0
- full  output  1  count==DEPTH
- overrun  output  1  sticky byte-lost flag
- irq  output  1  interrupt request

Function
REQ-008 SHALL implement FSM states IDLE, ARM, WAIT, CAPTURE, RECOVER.
REQ-009 SHALL transition from IDLE to ARM when enable=1; otherwise IDLE SHALL hold.
REQ-010 SHALL transition from ARM to WAIT unconditionally after one cycle.
REQ-011 SHALL apply these WAIT transitions, with rx_done taking priority:
- rx_done=1 -> CAPTURE
- else enable=0 and rx_busy=0 -> IDLE
- else hold
REQ-012 SHALL transition from CAPTURE to RECOVER unconditionally after one cycle.
REQ-013 SHALL transition from RECOVER to WAIT if enable=1, else to IDLE.
REQ-014 SHALL drive rx_en=1 only in WAIT and CAPTURE.
REQ-015 SHALL drive rx_rst=1 in ARM, in RECOVER, and in any cycle with clear=1; rx_rst SHALL be 0 otherwise.
REQ-016 SHALL sample rx_byte in CAPTURE and push it if full=0; if full=1 (before any same-cycle pop) it SHALL drop the byte and set overrun.
REQ-017 SHALL push at most one byte per frame: the capture-to-next-capture minimum is 3 cycles.
REQ-018 SHALL implement the FIFO as a circular buffer:
- read/write pointers of log2(DEPTH) bits, wrapping DEPTH-1 -> 0
- count range 0..DEPTH
REQ-019 SHALL present mem[rd_ptr] on rd_data when empty=0; when empty=1 rd_data SHALL hold its last value.
REQ-020 SHALL pop on rd_req=1 with empty=0; rd_req with empty=1 SHALL be ignored (no pointer or count change).
REQ-021 SHALL handle a same-cycle push and pop by performing both with count unchanged; when full=1 the pop frees the slot, the push succeeds, and overrun is not set.
REQ-022 SHALL compute empty, full and count from registered state with no combinational path from rd_req.
REQ-023 SHALL treat overrun as sticky: it SHALL clear only on ovr_clr=1 or clear=1; a set event and ovr_clr in the same cycle SHALL leave overrun set.
REQ-024 SHALL drive irq = overrun OR (count >= max(irq_level,1)) OR (irq_level > DEPTH AND full).
REQ-025 SHALL, on clear=1, in the same edge, force IDLE, zero pointers and count, and clear overrun; any concurrent push or pop SHALL be discarded.
REQ-026 SHALL, when enable drops mid-frame (rx_busy=1), remain in WAIT until the frame completes and is captured, then go to IDLE via RECOVER.

Reset
REQ-027 SHALL, while arst_n=0, asynchronously force these values:
- state=IDLE
- pointers=0, count=0
- empty=1, full=0
- overrun=0, irq=0
- rx_en=0, rx_rst=0
- rd_data=0
REQ-028 SHALL leave FIFO storage contents undefined on reset; they SHALL never be observable on rd_data while empty=1 after reset.
REQ-029 SHALL resume normal operation on the first clk edge after arst_n deasserts.

Verification
REQ-030 SHALL cover these directed scenarios:
- enable=1 from reset -> rx_rst high one cycle (ARM), then rx_en=1.
- rx_done with rx_byte=0xA5 -> next cycle count=1, rd_data=0xA5, rx_rst pulse in RECOVER.
- Five frames 0x01..0x05 with no reads, DEPTH=4 -> count=4, full=1, overrun=1, irq=1, rd_data=0x01; four pops return 0x01..0x04, then empty=1.
- Full FIFO, rd_req coincident with CAPTURE of 0x77 -> count stays 4, overrun=0, last entry 0x77.
- irq_level=2: after one byte irq=0; after two bytes irq=1; one pop gives irq=0.
- clear or arst_n asserted with count=3 and overrun=1 -> count=0, empty=1, overrun=0, state IDLE, rx_en=0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences the bit-level receiver through arm/wait/capture/recover
// and buffers received bytes in a first-word-fall-through FIFO with overrun and interrupt status.
module uart_rx_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             rx_done,
  input  logic             rx_busy,
  input  logic [WIDTH-1:0] rx_byte,
  output logic             rx_en,
  output logic             rx_rst,
  input  logic             rd_req,
  input  logic             ovr_clr,
  input  logic [CW-1:0]    irq_level,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full,
  output logic             overrun,
  output logic             irq
);

  localparam int            PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_MAX = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT,
    ST_CAPTURE,
    ST_RECOVER
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovr_q, ovr_d;
  logic [WIDTH-1:0] last_q, last_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             capture;
  logic             push;
  logic             pop;
  logic             ovr_set;
  logic [CW-1:0]    irq_thr;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (enable) state_d = ST_ARM;
      ST_ARM:     state_d = ST_WAIT;
      ST_WAIT: begin
        if (rx_done)                  state_d = ST_CAPTURE;
        else if (!enable && !rx_busy) state_d = ST_IDLE;
      end
      ST_CAPTURE: state_d = ST_RECOVER;
      ST_RECOVER: state_d = enable ? ST_WAIT : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (clear) state_d = ST_IDLE;
  end

  assign rx_en = (state_q == ST_WAIT) || (state_q == ST_CAPTURE);
  // Gated by arst_n so a clear held during reset cannot leak a receiver reset pulse.
  assign rx_rst = arst_n & ((state_q == ST_ARM) || (state_q == ST_RECOVER) || clear);

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign overrun = ovr_q;

  // A full FIFO still accepts the captured byte when a pop frees the head slot in the same cycle.
  assign capture = (state_q == ST_CAPTURE);
  assign pop     = rd_req && !empty;
  assign push    = capture && (!full || pop);
  assign ovr_set = capture && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    last_d   = empty ? last_q : mem[rd_ptr_q];
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovr_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (ovr_set)      ovr_d = 1'b1;
      else if (ovr_clr) ovr_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage has no reset; it is only visible through rd_data once count says the slot is valid.
  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr_q] <= rx_byte;
  end

  // While empty, rd_data holds the last head presented (zero straight after reset).
  assign rd_data = empty ? last_q : mem[rd_ptr_q];

  assign irq_thr = (irq_level == '0) ? CW'(1) : irq_level;
  assign irq     = ovr_q || (count_q >= irq_thr) || ((irq_level > DEPTH_C) && full);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: a directed vector table, hand-written corner sequences,
// and a randomized run compared against a queue-based reference model.
module tb_uart_rx_ctrl;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int NV    = 23;

  localparam int P_IDLE    = 0;
  localparam int P_ARM     = 1;
  localparam int P_WAIT    = 2;
  localparam int P_CAPTURE = 3;
  localparam int P_RECOVER = 4;

  logic             clk = 1'b0;
  logic             arst_n = 1'b0;
  logic             clear = 1'b0;
  logic             enable = 1'b0;
  logic             rx_done = 1'b0;
  logic             rx_busy = 1'b0;
  logic [WIDTH-1:0] rx_byte = '0;
  logic             rd_req = 1'b0;
  logic             ovr_clr = 1'b0;
  logic [CW-1:0]    irq_level = '0;
  logic             rx_en;
  logic             rx_rst;
  logic [WIDTH-1:0] rd_data;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overrun;
  logic             irq;

  int total = 0;
  int bad   = 0;

  uart_rx_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .clear     (clear),
    .enable    (enable),
    .rx_done   (rx_done),
    .rx_busy   (rx_busy),
    .rx_byte   (rx_byte),
    .rx_en     (rx_en),
    .rx_rst    (rx_rst),
    .rd_req    (rd_req),
    .ovr_clr   (ovr_clr),
    .irq_level (irq_level),
    .rd_data   (rd_data),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overrun   (overrun),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int clr, en, done, busy, data, rd, oc, lvl;
    int x_en, x_rst, x_cnt, x_emp, x_full, x_ovr, x_irq, x_rd;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag, input logic [31:0] x_en, input logic [31:0] x_rst,
                            input logic [31:0] x_cnt, input logic [31:0] x_emp,
                            input logic [31:0] x_full, input logic [31:0] x_ovr,
                            input logic [31:0] x_irq, input logic [31:0] x_rd);
    check({tag, "_rx_en"},   32'(rx_en),   x_en);
    check({tag, "_rx_rst"},  32'(rx_rst),  x_rst);
    check({tag, "_count"},   32'(count),   x_cnt);
    check({tag, "_empty"},   32'(empty),   x_emp);
    check({tag, "_full"},    32'(full),    x_full);
    check({tag, "_overrun"}, 32'(overrun), x_ovr);
    check({tag, "_irq"},     32'(irq),     x_irq);
    check({tag, "_rd_data"}, 32'(rd_data), x_rd);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // One receiver frame from WAIT: done while waiting, optional pop/ovr_clr during the capture
  // cycle, receiver reset seen in recover, back in WAIT with rx_done low.
  task automatic send(input logic [7:0] b, input logic pop_at_cap, input logic oc_at_cap);
    rx_done = 1'b1;
    rx_byte = b;
    next_cycle();
    rd_req  = pop_at_cap;
    ovr_clr = oc_at_cap;
    next_cycle();
    rd_req  = 1'b0;
    ovr_clr = 1'b0;
    next_cycle();
    rx_done = 1'b0;
  endtask

  task automatic pop_one();
    rd_req = 1'b1;
    next_cycle();
    rd_req = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state for the randomized run.
  logic [7:0] mq[$];
  int         m_st;
  logic       m_ovr;
  logic [7:0] m_last;
  logic       rv_busy, rv_done;
  int         rv_timer;
  logic [7:0] rv_byte;

  initial begin
    //            clr en dn bz data  rd oc lv | en rst cnt emp full ovr irq rd
    vecs[0]  = '{0, 1, 0, 0, 'h00, 0, 0, 2,  0, 0, 0, 1, 0, 0, 0, 'h00};
    vecs[1]  = '{0, 1, 0, 0, 'h00, 0, 0, 2,  0, 1, 0, 1, 0, 0, 0, 'h00};
    vecs[2]  = '{0, 1, 0, 0, 'h00, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h00};
    vecs[3]  = '{0, 1, 1, 0, 'hA5, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h00};
    vecs[4]  = '{0, 1, 1, 0, 'hA5, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h00};
    vecs[5]  = '{0, 1, 1, 0, 'hA5, 0, 0, 2,  0, 1, 1, 0, 0, 0, 0, 'hA5};
    vecs[6]  = '{0, 1, 0, 0, 'h00, 0, 0, 2,  1, 0, 1, 0, 0, 0, 0, 'hA5};
    vecs[7]  = '{0, 1, 1, 0, 'h3C, 0, 0, 2,  1, 0, 1, 0, 0, 0, 0, 'hA5};
    vecs[8]  = '{0, 1, 1, 0, 'h3C, 0, 0, 2,  1, 0, 1, 0, 0, 0, 0, 'hA5};
    vecs[9]  = '{0, 1, 1, 0, 'h3C, 0, 0, 2,  0, 1, 2, 0, 0, 0, 1, 'hA5};
    vecs[10] = '{0, 1, 0, 0, 'h00, 1, 0, 2,  1, 0, 2, 0, 0, 0, 1, 'hA5};
    vecs[11] = '{0, 1, 0, 0, 'h00, 0, 0, 2,  1, 0, 1, 0, 0, 0, 0, 'h3C};
    vecs[12] = '{0, 1, 0, 0, 'h00, 1, 0, 2,  1, 0, 1, 0, 0, 0, 0, 'h3C};
    vecs[13] = '{0, 1, 0, 0, 'h00, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[14] = '{0, 1, 0, 0, 'h00, 1, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[15] = '{0, 0, 0, 1, 'h00, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[16] = '{0, 0, 0, 1, 'h00, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[17] = '{0, 0, 1, 0, 'h5A, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[18] = '{0, 0, 1, 0, 'h5A, 0, 0, 2,  1, 0, 0, 1, 0, 0, 0, 'h3C};
    vecs[19] = '{0, 0, 1, 0, 'h5A, 0, 0, 2,  0, 1, 1, 0, 0, 0, 0, 'h5A};
    vecs[20] = '{0, 0, 0, 0, 'h00, 0, 0, 0,  0, 0, 1, 0, 0, 0, 1, 'h5A};
    vecs[21] = '{1, 0, 0, 0, 'h00, 0, 0, 0,  0, 1, 1, 0, 0, 0, 1, 'h5A};
    vecs[22] = '{0, 0, 0, 0, 'h00, 0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 'h5A};

    // Reset state, observed while reset is still asserted.
    repeat (2) next_cycle();
    #1;
    check_outs("reset", 0, 0, 0, 1, 0, 0, 0, 0);
    next_cycle();
    arst_n = 1'b1;

    // Directed vector table: one row per cycle, outputs compared before the row's clock edge.
    for (int i = 0; i < NV; i++) begin
      clear     = vecs[i].clr[0];
      enable    = vecs[i].en[0];
      rx_done   = vecs[i].done[0];
      rx_busy   = vecs[i].busy[0];
      rx_byte   = 8'(vecs[i].data);
      rd_req    = vecs[i].rd[0];
      ovr_clr   = vecs[i].oc[0];
      irq_level = 3'(vecs[i].lvl);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].x_en, vecs[i].x_rst, vecs[i].x_cnt,
                 vecs[i].x_emp, vecs[i].x_full, vecs[i].x_ovr, vecs[i].x_irq, vecs[i].x_rd);
      next_cycle();
    end
    clear = 1'b0; rx_done = 1'b0; rx_busy = 1'b0; rd_req = 1'b0; ovr_clr = 1'b0;

    // Five frames with no reads into a four-entry FIFO.
    irq_level = 3'd4;
    enable    = 1'b1;
    next_cycle();
    next_cycle();
    check_outs("b_wait", 1, 0, 0, 1, 0, 0, 0, 'h5A);
    for (int i = 1; i <= 4; i++) send(8'(i), 1'b0, 1'b0);
    check_outs("b_full", 1, 0, 4, 0, 1, 0, 1, 'h01);
    send(8'h05, 1'b0, 1'b0);
    check_outs("b_ovr", 1, 0, 4, 0, 1, 1, 1, 'h01);
    for (int i = 1; i <= 4; i++) begin
      check($sformatf("b_pop%0d_data", i), 32'(rd_data), i);
      pop_one();
    end
    check_outs("b_drained", 1, 0, 0, 1, 0, 1, 1, 'h04);
    ovr_clr = 1'b1;
    next_cycle();
    ovr_clr = 1'b0;
    check_outs("b_ovr_clr", 1, 0, 0, 1, 0, 0, 0, 'h04);

    // Full FIFO with a pop coincident with capture: both happen, no overrun.
    for (int i = 0; i < 4; i++) send(8'(8'h11 + i), 1'b0, 1'b0);
    send(8'h77, 1'b1, 1'b0);
    check_outs("c_push_pop", 1, 0, 4, 0, 1, 0, 1, 'h12);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("c_pop%0d_data", i), 32'(rd_data), 32'(8'h12 + i));
      pop_one();
    end
    check_outs("c_last", 1, 0, 1, 0, 0, 0, 0, 'h77);
    pop_one();
    check_outs("c_empty", 1, 0, 0, 1, 0, 0, 0, 'h77);

    // Threshold above DEPTH fires only on full; overrun set beats same-cycle ovr_clr; soft clear.
    for (int i = 0; i < 4; i++) send(8'(8'h21 + i), 1'b0, 1'b0);
    irq_level = 3'd6;
    #1;
    check("d_irq_full", 32'(irq), 1);
    send(8'h99, 1'b0, 1'b1);
    check_outs("d_set_wins", 1, 0, 4, 0, 1, 1, 1, 'h21);
    pop_one();
    check_outs("d_cnt3", 1, 0, 3, 0, 0, 1, 1, 'h22);
    clear = 1'b1;
    #1;
    check("d_clear_rst", 32'(rx_rst), 1);
    next_cycle();
    clear = 1'b0;
    #1;
    check_outs("d_cleared", 0, 0, 0, 1, 0, 0, 0, 'h22);
    next_cycle();
    check_outs("d_rearm", 0, 1, 0, 1, 0, 0, 0, 'h22);
    next_cycle();

    // Asynchronous reset with count=3 and overrun set, then resume on the first edge.
    irq_level = 3'd4;
    for (int i = 0; i < 5; i++) send(8'(8'h31 + i), 1'b0, 1'b0);
    pop_one();
    check_outs("e_pre", 1, 0, 3, 0, 0, 1, 1, 'h32);
    #2;
    arst_n = 1'b0;
    #1;
    check_outs("e_async", 0, 0, 0, 1, 0, 0, 0, 0);
    next_cycle();
    arst_n = 1'b1;
    next_cycle();
    check_outs("e_resume", 0, 1, 0, 1, 0, 0, 0, 0);
    next_cycle();
    check_outs("e_wait", 1, 0, 0, 1, 0, 0, 0, 0);

    // Randomized run against the reference model.
    arst_n = 1'b0;
    enable = 1'b0;
    next_cycle();
    arst_n = 1'b1;
    mq.delete();
    m_st     = P_IDLE;
    m_ovr    = 1'b0;
    m_last   = '0;
    rv_busy  = 1'b0;
    rv_done  = 1'b0;
    rv_timer = 0;
    rv_byte  = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int   sz, lvl, thr;
      logic e_en, e_rst, e_irq, cap, do_pop, do_push;
      logic [7:0] e_rd;
      clear   = ($urandom % 100) == 0;
      enable  = ($urandom % 12) != 0;
      rd_req  = (((cyc / 400) % 2) == 0) ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
      ovr_clr = ($urandom % 25) == 0;
      if (($urandom % 60) == 0) irq_level = 3'($urandom % 8);
      rx_done = rv_done;
      rx_busy = rv_busy;
      rx_byte = rv_done ? rv_byte : 8'($urandom);
      #1;
      sz    = mq.size();
      e_en  = (m_st == P_WAIT) || (m_st == P_CAPTURE);
      e_rst = (m_st == P_ARM) || (m_st == P_RECOVER) || clear;
      lvl   = int'(irq_level);
      thr   = (lvl < 1) ? 1 : lvl;
      e_irq = m_ovr || (sz >= thr) || ((lvl > DEPTH) && (sz == DEPTH));
      e_rd  = m_last;
      if (sz > 0) e_rd = mq[0];
      check_outs($sformatf("rnd%0d", cyc), 32'(e_en), 32'(e_rst), sz, 32'(sz == 0),
                 32'(sz == DEPTH), 32'(m_ovr), 32'(e_irq), 32'(e_rd));

      m_last = e_rd;
      if (clear) begin
        mq.delete();
        m_ovr = 1'b0;
        m_st  = P_IDLE;
      end else begin
        cap     = (m_st == P_CAPTURE);
        do_pop  = rd_req && (sz > 0);
        do_push = cap && ((sz < DEPTH) || do_pop);
        if (cap && (sz == DEPTH) && !do_pop) m_ovr = 1'b1;
        else if (ovr_clr)                    m_ovr = 1'b0;
        if (do_pop)  void'(mq.pop_front());
        if (do_push) mq.push_back(rx_byte);
        case (m_st)
          P_IDLE:    if (enable) m_st = P_ARM;
          P_ARM:     m_st = P_WAIT;
          P_WAIT:    if (rx_done) m_st = P_CAPTURE;
                     else if (!enable && !rx_busy) m_st = P_IDLE;
          P_CAPTURE: m_st = P_RECOVER;
          default:   m_st = enable ? P_WAIT : P_IDLE;
        endcase
      end

      if (e_rst) begin
        rv_busy = 1'b0;
        rv_done = 1'b0;
      end else if (rv_busy) begin
        rv_timer--;
        if (rv_timer == 0) begin
          rv_busy = 1'b0;
          rv_done = 1'b1;
          rv_byte = 8'($urandom);
        end
      end else if (!rv_done && e_en && (($urandom % 3) == 0)) begin
        rv_busy  = 1'b1;
        rv_timer = 1 + int'($urandom % 4);
      end
      next_cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
